// File: rtl/mul_pipe_unit_pkg.sv
// Shared types and helpers for the pipelined RV32M multiplier.
// Operation encoding matches the funct3 ordering decode hands over.
package mul_pipe_unit_pkg;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'd0,
    MUL_OP_MULH   = 2'd1,
    MUL_OP_MULHSU = 2'd2,
    MUL_OP_MULHU  = 2'd3
  } mul_op_t;

  localparam int MUL_STAGES_DEFAULT = 4;

  function automatic logic op_a_signed(mul_op_t op);
    return op != MUL_OP_MULHU;
  endfunction

  function automatic logic op_b_signed(mul_op_t op);
    return (op == MUL_OP_MUL) || (op == MUL_OP_MULH);
  endfunction

  // Only plain MUL returns the low word; every high-half mode returns the upper word.
  function automatic logic op_returns_low(mul_op_t op);
    return op == MUL_OP_MUL;
  endfunction

endpackage

// File: rtl/mul_pipe_unit_reg.sv
// One pipeline slot of the multiplier: a valid bit plus an opaque payload.
// Flush beats stall; the payload only loads on a valid entry so it holds between uses.
module mul_pipe_reg
  import mul_pipe_unit_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall_i,
  input  logic         flush_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // NOTE: state is written with <= so every slot samples its neighbour's old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      // NOTE: the payload is reset as well because it drives out_rd/out_result directly.
      data_q  <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (!stall_i) begin
      valid_q <= valid_i;
      if (valid_i) begin
        data_q <= data_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/mul_pipe_unit.sv
// Parametrised pipelined RV32M multiplier with stall, issue-kill, flush and
// a destination busy mask for the hazard unit.
module mul_pipe_unit
  import mul_pipe_unit_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = MUL_STAGES_DEFAULT,
  parameter int NREGS  = 32,
  localparam int RD_W  = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [RD_W-1:0] in_rd,
  input  logic            stall_in,
  input  logic            kill_in,
  input  logic            flush_in,
  output logic            out_valid,
  output logic [RD_W-1:0] out_rd,
  output logic [XLEN-1:0] out_result,
  output logic [NREGS-1:0] busy_mask
);

  localparam int LAST = STAGES - 1;

  typedef struct packed {
    mul_op_t          op;
    logic [RD_W-1:0]  rd;
    logic [2*XLEN-1:0] prod;
  } mul_entry_t;

  mul_op_t                 issue_op;
  logic                    accept;
  logic signed [XLEN:0]    a_ext;
  logic signed [XLEN:0]    b_ext;
  logic signed [2*XLEN+1:0] prod_full;
  logic                    unused_prod_hi;

  logic [STAGES-1:0] stg_valid_d;
  logic [STAGES-1:0] stg_valid_q;
  mul_entry_t        stg_data_d [STAGES];
  mul_entry_t        stg_data_q [STAGES];

  assign issue_op = mul_op_t'(in_op);
  assign accept   = in_valid & ~kill_in & ~stall_in & ~flush_in;

  // One extra bit lets a single signed multiply cover all four sign combinations.
  assign a_ext     = {op_a_signed(issue_op) & in_a[XLEN-1], in_a};
  assign b_ext     = {op_b_signed(issue_op) & in_b[XLEN-1], in_b};
  assign prod_full = a_ext * b_ext;

  // The two guard bits above 2*XLEN never reach a result word.
  assign unused_prod_hi = ^prod_full[2*XLEN+1:2*XLEN];

  // The product is formed at issue and then carried; register balancing in
  // synthesis is expected to pull the trailing slots back into the multiplier.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign stg_valid_d[k] = accept;
      assign stg_data_d[k]  = '{op: issue_op, rd: in_rd, prod: prod_full[2*XLEN-1:0]};
    end else begin : g_body
      assign stg_valid_d[k] = stg_valid_q[k-1];
      assign stg_data_d[k]  = stg_data_q[k-1];
    end

    mul_pipe_reg #(
      .W($bits(mul_entry_t))
    ) u_reg (
      .clk     (clk),
      .rst     (rst),
      .stall_i (stall_in),
      .flush_i (flush_in),
      .valid_i (stg_valid_d[k]),
      .data_i  (stg_data_d[k]),
      .valid_o (stg_valid_q[k]),
      .data_o  (stg_data_q[k])
    );
  end

  assign out_valid  = stg_valid_q[LAST];
  assign out_rd     = stg_data_q[LAST].rd;
  assign out_result = op_returns_low(stg_data_q[LAST].op)
                    ? stg_data_q[LAST].prod[XLEN-1:0]
                    : stg_data_q[LAST].prod[2*XLEN-1:XLEN];

  // x0 is never a hazard, so it is kept out of the mask.
  always_comb begin
    // NOTE: the default assignment first keeps this block free of latches.
    busy_mask = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (stg_valid_q[k] && (stg_data_q[k].rd != '0)) begin
        busy_mask[stg_data_q[k].rd] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mul_pipe_unit.sv
// Directed bench for mul_pipe_unit (STAGES=3): a queue-based scoreboard checks
// every result, while cycle-exact checks cover latency, stall, kill, flush and reset.
module tb_mul_pipe_unit;
  import mul_pipe_unit_pkg::*;

  localparam int XLEN   = 32;
  localparam int STAGES = 3;
  localparam int NREGS  = 32;
  localparam int RD_W   = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [1:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [RD_W-1:0]  in_rd;
  logic             stall_in;
  logic             kill_in;
  logic             flush_in;
  logic             out_valid;
  logic [RD_W-1:0]  out_rd;
  logic [XLEN-1:0]  out_result;
  logic [NREGS-1:0] busy_mask;

  typedef struct {
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] res;
  } exp_t;

  exp_t            sb_q[$];
  logic [XLEN-1:0] cur_exp;
  int              checks = 0;
  int              errors = 0;
  bit              seen   = 1'b0;

  mul_pipe_unit #(
    .XLEN   (XLEN),
    .STAGES (STAGES),
    .NREGS  (NREGS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_rd      (in_rd),
    .stall_in   (stall_in),
    .kill_in    (kill_in),
    .flush_in   (flush_in),
    .out_valid  (out_valid),
    .out_rd     (out_rd),
    .out_result (out_result),
    .busy_mask  (busy_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                       input logic st, input logic kl, input logic fl);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_rd    = rd;
    cur_exp  = exp;
    stall_in = st;
    kill_in  = kl;
    flush_in = fl;
  endtask

  task automatic idle(input logic st = 1'b0);
    drive(1'b0, 2'd0, 32'd0, 32'd0, 5'd0, 32'd0, st, 1'b0, 1'b0);
  endtask

  // Advance one cycle; the scoreboard follows the accept/flush/reset rules of the edge.
  task automatic tick();
    @(posedge clk);
    if (rst || flush_in) sb_q.delete();
    else if (in_valid && !kill_in && !stall_in) sb_q.push_back('{in_rd, cur_exp});
    #1;
  endtask

  // Monitor: one comparison per entry that reaches the output, frozen or not.
  always @(negedge clk) begin
    if (out_valid && !seen) begin
      seen = 1'b1;
      if (sb_q.size() == 0) begin
        check("spurious_out_valid", {63'd0, out_valid}, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_rd", {59'd0, out_rd}, {59'd0, e.rd});
        check("sb_result", {32'd0, out_result}, {32'd0, e.res});
      end
    end
  end

  always @(posedge clk) begin
    if (rst || flush_in || !stall_in) seen = 1'b0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [1:0]  v_op  [8] = '{MUL_OP_MUL, MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULHU,
                             MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULHU, MUL_OP_MUL};
  logic [31:0] v_a   [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'h80000000, 32'h80000000, 32'h80000000, 32'h12345678};
  logic [31:0] v_b   [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'h80000000, 32'h00000002, 32'h00000002, 32'h00000010};
  logic [31:0] v_exp [8] = '{32'h00000001, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFE,
                             32'h40000000, 32'hFFFFFFFF, 32'h00000001, 32'h23456780};

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_rd", {59'd0, out_rd}, 64'd0);
    check("rst_out_result", {32'd0, out_result}, 64'd0);
    check("rst_busy", {32'd0, busy_mask}, 64'd0);
    rst = 1'b0;
    tick();

    // Latency: MUL 7*6 into rd5, three cycles to the output.
    drive(1'b1, MUL_OP_MUL, 32'd7, 32'd6, 5'd5, 32'd42, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    check("lat_busy_c1", {32'd0, busy_mask}, 64'h20);
    check("lat_valid_c1", {63'd0, out_valid}, 64'd0);
    tick();
    check("lat_busy_c2", {32'd0, busy_mask}, 64'h20);
    check("lat_valid_c2", {63'd0, out_valid}, 64'd0);
    tick();
    check("lat_valid_c3", {63'd0, out_valid}, 64'd1);
    check("lat_rd_c3", {59'd0, out_rd}, 64'd5);
    check("lat_result_c3", {32'd0, out_result}, 64'd42);
    check("lat_busy_c3", {32'd0, busy_mask}, 64'h20);
    tick();
    check("lat_valid_c4", {63'd0, out_valid}, 64'd0);
    check("lat_busy_c4", {32'd0, busy_mask}, 64'd0);

    // All four modes plus sign-boundary operands, back to back.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, v_op[i], v_a[i], v_b[i], 5'(10 + i), v_exp[i], 1'b0, 1'b0, 1'b0);
      tick();
    end
    idle();
    repeat (4) tick();
    check("modes_busy_drained", {32'd0, busy_mask}, 64'd0);

    // Stall in cycles 2-3 holds back issue; results at cycles 5..8 in order.
    drive(1'b1, MUL_OP_MUL, 32'd3, 32'd1, 5'd1, 32'd3, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, MUL_OP_MUL, 32'd3, 32'd2, 5'd2, 32'd6, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, MUL_OP_MUL, 32'd3, 32'd3, 5'd3, 32'd9, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b1, MUL_OP_MUL, 32'd3, 32'd3, 5'd3, 32'd9, 1'b0, 1'b0, 1'b0);
    check("stall_valid_c4", {63'd0, out_valid}, 64'd0);
    tick();
    drive(1'b1, MUL_OP_MUL, 32'd3, 32'd4, 5'd4, 32'd12, 1'b0, 1'b0, 1'b0);
    check("stall_rd_c5", {59'd0, out_rd}, 64'd1);
    check("stall_valid_c5", {63'd0, out_valid}, 64'd1);
    tick();
    idle();
    for (int c = 6; c <= 8; c++) begin
      check($sformatf("stall_rd_c%0d", c), {59'd0, out_rd}, 64'(c - 4));
      check($sformatf("stall_valid_c%0d", c), {63'd0, out_valid}, 64'd1);
      tick();
    end
    check("stall_valid_c9", {63'd0, out_valid}, 64'd0);

    // Output frozen while stalled at the last stage.
    drive(1'b1, MUL_OP_MUL, 32'd4, 32'd4, 5'd9, 32'd16, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    tick();
    check("freeze_valid_c3", {63'd0, out_valid}, 64'd1);
    idle(1'b1);
    tick();
    check("freeze_valid_c4", {63'd0, out_valid}, 64'd1);
    check("freeze_rd_c4", {59'd0, out_rd}, 64'd9);
    check("freeze_result_c4", {32'd0, out_result}, 64'd16);
    tick();
    check("freeze_valid_c5", {63'd0, out_valid}, 64'd1);
    check("freeze_result_c5", {32'd0, out_result}, 64'd16);
    idle();
    tick();
    check("freeze_valid_c6", {63'd0, out_valid}, 64'd0);

    // Kill drops only the issuing instruction.
    drive(1'b1, MUL_OP_MUL, 32'd5, 32'd5, 5'd7, 32'd25, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, MUL_OP_MUL, 32'd9, 32'd9, 5'd8, 32'd81, 1'b0, 1'b1, 1'b0);
    check("kill_busy_c1", {32'd0, busy_mask}, 64'h80);
    tick();
    idle();
    check("kill_busy_c2", {32'd0, busy_mask}, 64'h80);
    tick();
    check("kill_valid_c3", {63'd0, out_valid}, 64'd1);
    check("kill_rd_c3", {59'd0, out_rd}, 64'd7);
    check("kill_busy_c3", {32'd0, busy_mask}, 64'h80);
    tick();
    check("kill_valid_c4", {63'd0, out_valid}, 64'd0);
    check("kill_busy_c4", {32'd0, busy_mask}, 64'd0);

    // Flush together with stall, three entries in flight and an issue dropped.
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, MUL_OP_MUL, 32'd2, 32'(i), 5'(i), 32'(2 * i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    check("flush_busy_before", {32'd0, busy_mask}, 64'hE);
    drive(1'b1, MUL_OP_MUL, 32'd2, 32'd4, 5'd4, 32'd8, 1'b1, 1'b0, 1'b1);
    tick();
    idle();
    check("flush_valid_c4", {63'd0, out_valid}, 64'd0);
    check("flush_busy_c4", {32'd0, busy_mask}, 64'd0);
    for (int c = 5; c <= 6; c++) begin
      tick();
      check($sformatf("flush_valid_c%0d", c), {63'd0, out_valid}, 64'd0);
    end

    // rd=0 flows normally without touching the busy mask.
    drive(1'b1, MUL_OP_MUL, 32'd9, 32'd9, 5'd0, 32'd81, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    check("rd0_busy_c1", {32'd0, busy_mask}, 64'd0);
    tick();
    check("rd0_busy_c2", {32'd0, busy_mask}, 64'd0);
    tick();
    check("rd0_valid_c3", {63'd0, out_valid}, 64'd1);
    check("rd0_rd_c3", {59'd0, out_rd}, 64'd0);
    check("rd0_busy_c3", {32'd0, busy_mask}, 64'd0);
    tick();

    // Reset mid-operation discards the entry.
    drive(1'b1, MUL_OP_MUL, 32'd1, 32'd1, 5'd0, 32'd1, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    rst = 1'b1;
    check("rstmid_busy_c1", {32'd0, busy_mask}, 64'd0);
    tick();
    rst = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      check($sformatf("rstmid_valid_c%0d", c), {63'd0, out_valid}, 64'd0);
      check($sformatf("rstmid_busy_c%0d", c), {32'd0, busy_mask}, 64'd0);
      tick();
    end

    repeat (4) tick();
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_pipe_unit.md
Name: mul_pipe_unit

Overview:
- Parametrised successor to the fixed-depth pipelined multiplier.
- Sits beside execute_stage: accepts decoded M-extension multiplies from decode and delivers results towards memory/write-back.
- Adds configurable width and depth, all four RV32M multiply modes, stall freeze, issue-kill, full flush, and a destination-register busy mask for hazard_module.

Parameters:
- XLEN, 32, operand/result width.
- STAGES, 4, accept-to-result latency in cycles (>=1).
- NREGS, 32, architectural register count; busy mask width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  multiply issued from decode this cycle.
- in_op  in  2  mode: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU (mul_op_t).
- in_a  in  XLEN  rs1 value (bypassed).
- in_b  in  XLEN  rs2 value (bypassed).
- in_rd  in  $clog2(NREGS)  destination register.
- stall_in  in  1  backward stall from memory; freezes the whole pipe.
- kill_in  in  1  branch taken in EXE; suppresses this cycle's issue only.
- flush_in  in  1  clears every in-flight entry.
- out_valid  out  1  result available.
- out_rd  out  $clog2(NREGS)  result destination.
- out_result  out  XLEN  result.
- busy_mask  out  NREGS  bit r set while an in-flight entry targets r.

Behaviour:
- Single clock domain; reset is synchronous, active-high.
- Reset: all stage valids 0; out_valid 0, out_rd 0, out_result 0, busy_mask 0. Reset mid-operation discards all entries with no late output.
- Accept: in_valid & ~kill_in & ~stall_in & ~flush_in. Entry occupies stage 0 at the next edge.
- Latency: an accepted entry appears on out_valid exactly STAGES edges later, absent stalls. Each stall cycle adds one cycle.
- Throughput: one accept per cycle; no internal back-pressure.
- Stall: when stall_in=1 every stage register, including the output, holds. The output stays stable while stalled.
- Kill: affects only the issuing instruction; older in-flight entries are preserved.
- Flush: clears all valids at the next edge and overrides stall_in. An issue in the same cycle is dropped.
- Priority: rst > flush_in > stall_in > normal advance.
- Arithmetic: operands are extended to XLEN+1 bits. a is signed for MUL/MULH/MULHSU; b is signed for MUL/MULH. Product width is 2*XLEN+2.
  - MUL returns bits [XLEN-1:0].
  - All other modes return bits [2*XLEN-1:XLEN].
- Retiming: internal split of the partial products across stages is free; only the cycle-level contract is fixed.
- rd=0: the entry flows normally and out_valid asserts with out_rd=0, but it never sets busy_mask bit 0.
- busy_mask: combinational OR of onehot(rd) over valid stages, including the output stage. Duplicate rd is fine (OR). Cleared in the cycle after the entry leaves the output stage.
- out_valid drops to 0 when the last stage is empty; out_rd and out_result hold their last value (don't-care).

Decomposition:
- mul_op_t enum and MUL_STAGES_DEFAULT go in constants_pkg.
- mul_entry_t struct (valid, op, rd, partial result) goes in structure_pkg.
- One sub-module is natural: mul_pipe_reg.
  - Single stage register with stall, flush and reset handling.
  - Instantiated STAGES times via generate, with compute logic between stages.

Test Plan:
- STAGES=3, issue MUL a=7 b=6 rd=5 at cycle 0 -> out_valid=1, out_rd=5, out_result=42 at cycle 3; busy_mask[5]=1 in cycles 1-3.
- a=b=0xFFFFFFFF with each mode -> MUL 0x00000001, MULH 0x00000000, MULHSU 0xFFFFFFFF, MULHU 0xFFFFFFFE.
- Back-to-back issues at cycles 0-3 (rd 1-4), stall_in high in cycles 2-3 -> results emerge at cycles 5,6,7,8 in order; output frozen while stalled.
- Issue at cycle 0 (rd=7), then issue with kill_in=1 at cycle 1 (rd=8) -> only rd=7 result at cycle 3; busy_mask[8] never set.
- Three entries in flight, flush_in with stall_in=1 simultaneously -> next cycle all valids 0, busy_mask=0, no out_valid.
- Issue rd=0, then assert rst at cycle 1 -> busy_mask stays 0, out_valid stays 0 through cycle 5.
